// File: rtl/sel_rr_arb_if.sv
// sel_rr_arb_if -- bus bundle for the selector / round-robin arbiter.
//   in_data   : CH*N  channel k data at bits [k*N+N-1 : k*N]
//   in_valid  : CH    per-channel valid
//   in_ready  : CH    per-channel accept strobe (one-hot or zero)
//   out_data  : N     registered selected data
//   out_ch    : SW    registered index of the channel held in out_data
//   out_valid : 1     registered output valid
//   out_ready : 1     downstream accept
// Modports: slave = arbiter side, master = the side driving channels and
// consuming the output.
interface sel_rr_arb_if #(
  parameter int N  = 2,
  parameter int SW = 2
);
  localparam int CH = 2 ** SW;

  logic [CH*N-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [N-1:0]    out_data;
  logic [SW-1:0]   out_ch;
  logic            out_valid;
  logic            out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/sel_rr_arb.sv
// sel_rr_arb -- N-bit, 2**SW channel selector with a registered output stage.
// mode=0 passes the channel picked by sel; mode=1 arbitrates round-robin,
// letting a channel keep the grant for up to BURST consecutive transfers.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   mode  : 0 = fixed select, 1 = round-robin
//   sel   : channel index used in fixed mode
//   bus   : sel_rr_arb_if.slave (channel inputs, accept strobes, output stage)
module sel_rr_arb #(
  parameter int N     = 2,
  parameter int SW    = 2,
  parameter int BURST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  sel_rr_arb_if.slave     bus
);
  localparam int CH = 2 ** SW;
  localparam int BW = $clog2(BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(BURST);

  logic [SW-1:0] lg;      // last granted channel
  logic [BW-1:0] bcnt;    // transfers in the current burst, saturates at BMAX

  logic          space;
  logic          grant_ok;
  logic          grant_hold;
  logic [SW-1:0] g;
  logic [SW-1:0] idx;
  logic          load;

  // The output register can take a word when empty or being drained now.
  assign space = !bus.out_valid || bus.out_ready;

  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    grant_ok   = 1'b0;
    grant_hold = 1'b0;
    g          = '0;
    idx        = '0;
    if (!mode) begin
      grant_ok = bus.in_valid[sel];
      g        = sel;
    end else if (bcnt < BMAX && bus.in_valid[lg]) begin
      grant_ok   = 1'b1;
      grant_hold = 1'b1;
      g          = lg;
    end else begin
      // Scan lg+1 .. lg+CH; the SW-bit add wraps, so the last step is lg.
      for (int d = 1; d <= CH; d++) begin
        idx = lg + SW'(d);
        if (!grant_ok && bus.in_valid[idx]) begin
          grant_ok = 1'b1;
          g        = idx;
        end
      end
    end
  end

  // Gating with rst_n keeps in_ready low for the whole reset.
  assign load         = rst_n && space && grant_ok;
  assign bus.in_ready = load ? (CH'(1) << g) : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  // NOTE: out_data is reset as well because a reset must discard any
  // registered word, not just mark it invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      lg            <= SW'(CH - 1);   // first RR search starts at channel 0
      bcnt          <= BMAX;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[g*N +: N];
      bus.out_ch    <= g;
      lg            <= g;
      if (!mode)
        bcnt <= BMAX;                 // fixed mode never leaves a burst open
      else if (grant_hold)
        bcnt <= bcnt + BW'(1);
      else
        bcnt <= BW'(1);
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sel_rr_arb.sv
// tb_sel_rr_arb -- drives a BURST=1 and a BURST=2 arbiter with identical
// inputs and compares both against an integer-level round-robin model.
module tb_sel_rr_arb;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [1:0] sel;

  always #5 clk = ~clk;

  sel_rr_arb_if #(.N(2), .SW(2)) b1 ();
  sel_rr_arb_if #(.N(2), .SW(2)) b2 ();

  sel_rr_arb #(.N(2), .SW(2), .BURST(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .bus(b1.slave));
  sel_rr_arb #(.N(2), .SW(2), .BURST(2)) u_b2 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .bus(b2.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model state, index 0 -> BURST=1, index 1 -> BURST=2.
  int burst [2] = '{1, 2};
  int m_lg  [2];
  int m_bc  [2];
  int m_ov  [2];
  int m_od  [2];
  int m_oc  [2];
  bit p_ld  [2];
  bit p_hold[2];
  int p_g   [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ov[k] = 0; m_od[k] = 0; m_oc[k] = 0;
      m_lg[k] = 3; m_bc[k] = burst[k];
    end
  endtask

  // Rules: fixed mode grants sel if valid; RR holds lg while its burst is
  // open, else takes the first valid channel after lg in circular order.
  task automatic model_grant(input int k, input bit m, input int s, input bit [3:0] v,
                             output bit ok, output int gg, output bit hold);
    ok = 0; gg = 0; hold = 0;
    if (!m) begin
      ok = v[s]; gg = s;
    end else if (m_bc[k] < burst[k] && v[m_lg[k]]) begin
      ok = 1; gg = m_lg[k]; hold = 1;
    end else begin
      for (int d = 1; d <= 4; d++) begin
        int c;
        c = (m_lg[k] + d) % 4;
        if (!ok && v[c]) begin ok = 1; gg = c; end
      end
    end
  endtask

  // One clock cycle: drive just after a falling edge, check in_ready,
  // advance the model on the rising edge, check the registers on the
  // next falling edge.
  task automatic step(input bit r, input bit m, input logic [1:0] s,
                      input logic [3:0] v, input bit ordy, input logic [7:0] data);
    bit ok, hold;
    int gg;
    rst_n = r; mode = m; sel = s;
    b1.in_valid = v; b1.out_ready = ordy; b1.in_data = data;
    b2.in_valid = v; b2.out_ready = ordy; b2.in_data = data;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_grant(k, m, int'(s), v, ok, gg, hold);
      p_ld[k]   = r && (m_ov[k] == 0 || ordy) && ok;
      p_g[k]    = gg;
      p_hold[k] = hold;
    end
    check("b1.in_ready", 32'(b1.in_ready), p_ld[0] ? (32'd1 << p_g[0]) : 32'd0);
    check("b2.in_ready", 32'(b2.in_ready), p_ld[1] ? (32'd1 << p_g[1]) : 32'd0);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        m_ov[k] = 0; m_od[k] = 0; m_oc[k] = 0; m_lg[k] = 3; m_bc[k] = burst[k];
      end else if (p_ld[k]) begin
        m_ov[k] = 1;
        m_od[k] = int'((data >> (2 * p_g[k])) & 8'h3);
        m_oc[k] = p_g[k];
        m_lg[k] = p_g[k];
        m_bc[k] = !m ? burst[k] : (p_hold[k] ? m_bc[k] + 1 : 1);
      end else if (ordy) begin
        m_ov[k] = 0;
      end
    end
    @(negedge clk);
    check("b1.out_valid", 32'(b1.out_valid), m_ov[0]);
    check("b1.out_ch",    32'(b1.out_ch),    m_oc[0]);
    check("b1.out_data",  32'(b1.out_data),  m_od[0]);
    check("b2.out_valid", 32'(b2.out_valid), m_ov[1]);
    check("b2.out_ch",    32'(b2.out_ch),    m_oc[1]);
    check("b2.out_data",  32'(b2.out_data),  m_od[1]);
  endtask

  localparam logic [7:0] D0123 = 8'b11_10_01_00;

  initial begin
    bit m_r;
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0;
    b1.in_valid = '0; b1.out_ready = 1'b0; b1.in_data = '0;
    b2.in_valid = '0; b2.out_ready = 1'b0; b2.in_data = '0;
    model_reset();
    @(negedge clk);

    // Reset with every channel valid: in_ready must stay zero.
    step(0, 1, 2'd0, 4'hf, 1, D0123);
    step(0, 0, 2'd1, 4'hf, 1, D0123);

    // Fixed mode, sel 0 for five cycles, then sel 2.
    for (int i = 0; i < 5; i++) step(1, 0, 2'd0, 4'hf, 1, D0123);
    check("fixed_sel0_data", 32'(b1.out_data), 32'd0);
    step(1, 0, 2'd2, 4'hf, 1, D0123);
    check("fixed_sel2_data", 32'(b1.out_data), 32'd2);
    step(1, 0, 2'd2, 4'hf, 1, D0123);

    // Round-robin from reset: BURST=1 gives 0,1,2,3,..; BURST=2 gives 0,0,1,1,..
    step(0, 1, 2'd0, 4'hf, 1, D0123);
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 2'd0, 4'hf, 1, D0123);
      check("rr_b1_seq", 32'(b1.out_ch), 32'(i % 4));
      check("rr_b2_seq", 32'(b2.out_ch), 32'((i / 2) % 4));
    end

    // BURST=2: ch1 drops valid after its first grant of a burst.
    step(0, 1, 2'd0, 4'hf, 1, D0123);
    step(1, 1, 2'd0, 4'hf, 1, D0123);
    step(1, 1, 2'd0, 4'hf, 1, D0123);
    step(1, 1, 2'd0, 4'hf, 1, D0123);   // b2 grants ch1
    step(1, 1, 2'd0, 4'hd, 1, D0123);   // ch1 gone -> ch2
    check("b2_drop_to_ch2", 32'(b2.out_ch), 32'd2);
    step(1, 1, 2'd0, 4'hf, 1, D0123);   // burst of ch2 continues
    check("b2_ch2_burst", 32'(b2.out_ch), 32'd2);

    // Stall three cycles, then release.
    for (int i = 0; i < 3; i++) step(1, 1, 2'd0, 4'hf, 0, D0123);
    step(1, 1, 2'd0, 4'hf, 1, D0123);

    // Only ch2 valid: back-to-back grants with no bubble.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 2'd0, 4'h4, 1, D0123);
      check("only_ch2", {b1.out_valid, 6'd0, b1.out_ch}, {1'b1, 6'd0, 2'd2});
    end

    // Reset while a word is held, then round-robin restarts at ch0.
    step(1, 1, 2'd0, 4'hf, 0, D0123);
    step(0, 1, 2'd0, 4'hf, 0, D0123);
    check("rst_mid_valid", 32'(b1.out_valid), 32'd0);
    step(1, 1, 2'd0, 4'hf, 1, D0123);
    check("post_rst_ch0", 32'(b1.out_ch), 32'd0);

    // Randomized traffic.
    m_r = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) m_r = ~m_r;
      step($urandom_range(39) != 0, m_r, 2'($urandom), 4'($urandom),
           $urandom_range(3) != 0, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sel_rr_arb.md
SEL_RR_ARB -- requirements
Module: sel_rr_arb

Interface
REQ-001 Parameter N, default 2: data width per channel, N >= 1.
REQ-002 Parameter SW, default 2: select width; channel count CH = 2**SW (local, derived).
REQ-003 Parameter BURST, default 1: max consecutive round-robin grants to one channel, BURST >= 1.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 mode  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-007 sel  input  SW  channel index used in fixed mode.
REQ-008 in_data  input  CH*N  channel k data at bits [k*N+N-1 : k*N].
REQ-009 in_valid  input  CH  per-channel valid.
REQ-010 in_ready  output  CH  per-channel accept strobe, combinational, one-hot or zero.
REQ-011 out_data  output  N  registered selected data.
REQ-012 out_ch  output  SW  registered index of the channel in out_data.
REQ-013 out_valid  output  1  registered output valid.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 space = !out_valid || out_ready; a transfer on channel g (load) occurs when space && grant exists; in_ready[g] = load, all other bits 0.
REQ-016 Fixed mode: grant exists only if in_valid[sel]; g = sel; no other channel is ever granted.
REQ-017 Round-robin state: lg (last granted channel, SW bits) and bcnt (transfers in current burst, saturating at BURST).
REQ-018 RR hold: if bcnt < BURST and in_valid[lg], g = lg.
REQ-019 RR search otherwise: g = first valid channel scanning lg+1, lg+2, ... modulo CH, ending at lg itself; no valid channel -> no grant.
REQ-020 RR load: lg <= g; bcnt <= bcnt+1 if granted by hold, else bcnt <= 1.
REQ-021 Fixed-mode load: lg <= g, bcnt <= BURST (no hold carried into RR mode).
REQ-022 On load: out_data <= in_data slice g, out_ch <= g, out_valid <= 1 (latency 1 cycle, full throughput, no bubble when out_ready held high).
REQ-023 No load and out_ready high: out_valid <= 0; out_data, out_ch hold value.
REQ-024 out_valid && !out_ready: out_data, out_ch, out_valid, lg, bcnt all hold; in_ready = 0.
REQ-025 mode or sel changes take effect on the grant evaluated in the same cycle; an already registered word is never altered.
REQ-026 BURST = 1 yields pure round-robin; channel g waits at most (CH-1)*BURST transfers while valid.

Reset
REQ-027 While rst_n low at a clock edge: out_valid <= 0, out_data <= 0, out_ch <= 0, lg <= CH-1, bcnt <= BURST.
REQ-028 in_ready is forced to all-zero while rst_n is low, regardless of other inputs.
REQ-029 Reset mid-transfer discards the registered word; first RR grant after reset searches from channel 0.

Verification (N=2, SW=2, in_data ch0..3 = 0,1,2,3 unless stated)
REQ-030 mode=0, sel=0, all valid, out_ready=1 for 5 cycles, then sel=2 -> out_data 0, out_ch 0 one cycle after first edge, out_data 2 one cycle after sel change; in_ready = 0001 then 0100.
REQ-031 mode=1, BURST=1, all valid, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 with out_valid continuously high.
REQ-032 mode=1, BURST=2, all valid -> out_ch 0,0,1,1,2,2,3,3,0; ch1 dropping valid during its burst -> next grant ch2, bcnt=1.
REQ-033 out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch unchanged, in_ready=0000; out_ready=1 -> next channel in RR order loaded same edge.
REQ-034 mode=1, only in_valid[2]=1, BURST=1 -> out_ch 2,2,2 back-to-back, no bubble.
REQ-035 rst_n low one cycle while out_valid=1 -> out_valid=0, out_data=0 next edge; after release all valid -> first out_ch = 0.
